// File: rtl/midi_src_arbiter.sv
// midi_src_arbiter: merges the u and c MIDI byte streams into one stream,
// switching sources only at message boundaries, with a stall timeout.
//
// Ports:
//   reg_clk, reset_reg_N        clock, synchronous active-low reset
//   byteready_x/cur_status_x/
//   midibyte_nr_x/midi_in_data_x  per-source byte strobe and fields (x=u,c)
//   ovf_clr                      clears both overflow flags
//   byteready/cur_status/
//   midibyte_nr/midi_in_data     merged registered byte stream
//   sel                          source of last output byte (1=u, 0=c)
//   locked                       multi-byte message in progress
//   timeout                      pulse on forced release of a stalled lock
//   ovf_u, ovf_c                 sticky drop-on-full flags
module midi_src_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       byteready_u,
  input  logic [7:0] cur_status_u,
  input  logic [7:0] midibyte_nr_u,
  input  logic [7:0] midi_in_data_u,
  input  logic       byteready_c,
  input  logic [7:0] cur_status_c,
  input  logic [7:0] midibyte_nr_c,
  input  logic [7:0] midi_in_data_c,
  input  logic       ovf_clr,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midi_in_data,
  output logic       sel,
  output logic       locked,
  output logic       timeout,
  output logic       ovf_u,
  output logic       ovf_c
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOCK_U = 2'd1;
  localparam logic [1:0] S_LOCK_C = 2'd2;

  function automatic logic [1:0] msg_len(input logic [7:0] st);
    logic [1:0] l;
    l = 2'd1;
    if (st[7]) begin
      case (st[7:4])
        4'h8, 4'h9, 4'hA, 4'hB, 4'hE: l = 2'd3;
        4'hC, 4'hD: l = 2'd2;
        default: begin
          if (st == 8'hF1 || st == 8'hF3) l = 2'd2;
          else if (st == 8'hF2) l = 2'd3;
        end
      endcase
    end
    return l;
  endfunction

  // Sysex ends on its F7 data byte; all else on its last index.
  function automatic logic msg_done(input logic [23:0] e);
    if (e[23:16] == 8'hF0) return e[7:0] == 8'hF7;
    return ({1'b0, e[15:8]} + 9'd1) >= {7'd0, msg_len(e[23:16])};
  endfunction

  logic [23:0] mem_u [FIFO_DEPTH];
  logic [23:0] mem_c [FIFO_DEPTH];
  logic [AW:0] wp_u, rp_u, wp_c, rp_c;
  logic empty_u, full_u, wr_u, pop_u;
  logic empty_c, full_c, wr_c, pop_c;
  logic [23:0] head_u, head_c, head;
  logic done, to_fire, last_u;
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt;

  assign empty_u = (wp_u == rp_u);
  assign empty_c = (wp_c == rp_c);
  assign full_u = (wp_u[AW] != rp_u[AW]) &&
                  (wp_u[AW-1:0] == rp_u[AW-1:0]);
  assign full_c = (wp_c[AW] != rp_c[AW]) &&
                  (wp_c[AW-1:0] == rp_c[AW-1:0]);
  // A pop in the same cycle frees the slot for a write on full.
  assign wr_u = byteready_u && (!full_u || pop_u);
  assign wr_c = byteready_c && (!full_c || pop_c);
  assign head_u = mem_u[rp_u[AW-1:0]];
  assign head_c = mem_c[rp_c[AW-1:0]];
  assign head = pop_u ? head_u : head_c;
  assign done = msg_done(head);
  assign locked = (state != S_IDLE);

  always_ff @(posedge reg_clk) begin
    if (wr_u)
      mem_u[wp_u[AW-1:0]] <=
        {cur_status_u, midibyte_nr_u, midi_in_data_u};
    if (wr_c)
      mem_c[wp_c[AW-1:0]] <=
        {cur_status_c, midibyte_nr_c, midi_in_data_c};
  end

  always_comb begin
    pop_u = 1'b0;
    pop_c = 1'b0;
    to_fire = 1'b0;
    unique case (state)
      S_IDLE: begin
        pop_u = !empty_u && (empty_c || !last_u);
        pop_c = !empty_c && !pop_u;
      end
      S_LOCK_U: begin
        pop_u = !empty_u;
        to_fire = empty_u && (cnt == CNT_MAX);
      end
      S_LOCK_C: begin
        pop_c = !empty_c;
        to_fire = empty_c && (cnt == CNT_MAX);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (pop_u || pop_c)
      state_nx = done ? S_IDLE : (pop_u ? S_LOCK_U : S_LOCK_C);
    else if (to_fire)
      state_nx = S_IDLE;
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      wp_u <= '0;
      rp_u <= '0;
      wp_c <= '0;
      rp_c <= '0;
      state <= S_IDLE;
      cnt <= '0;
      last_u <= 1'b0;
      byteready <= 1'b0;
      cur_status <= '0;
      midibyte_nr <= '0;
      midi_in_data <= '0;
      sel <= 1'b0;
      timeout <= 1'b0;
      ovf_u <= 1'b0;
      ovf_c <= 1'b0;
    end else begin
      if (wr_u) wp_u <= wp_u + PTR_ONE;
      if (pop_u) rp_u <= rp_u + PTR_ONE;
      if (wr_c) wp_c <= wp_c + PTR_ONE;
      if (pop_c) rp_c <= rp_c + PTR_ONE;
      state <= state_nx;
      byteready <= pop_u || pop_c;
      timeout <= to_fire;
      if (pop_u || pop_c) begin
        {cur_status, midibyte_nr, midi_in_data} <= head;
        sel <= pop_u;
      end
      if (state == S_IDLE && (pop_u || pop_c))
        last_u <= pop_u;
      if (to_fire)
        last_u <= (state == S_LOCK_U);
      if (state == S_IDLE || pop_u || pop_c || to_fire)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_ONE;
      ovf_u <= (byteready_u && full_u && !pop_u) ||
               (ovf_u && !ovf_clr);
      ovf_c <= (byteready_c && full_c && !pop_c) ||
               (ovf_c && !ovf_clr);
    end
  end

endmodule

// File: tb/tb_midi_src_arbiter.sv
// tb_midi_src_arbiter: table, directed and random checks of
// midi_src_arbiter against a queue-based reference model.
module tb_midi_src_arbiter;

  localparam int DEPTH = 4;
  localparam int TO = 16;

  logic reg_clk = 1'b0;
  logic reset_reg_N = 1'b0;
  logic byteready_u = 1'b0;
  logic [7:0] cur_status_u = '0;
  logic [7:0] midibyte_nr_u = '0;
  logic [7:0] midi_in_data_u = '0;
  logic byteready_c = 1'b0;
  logic [7:0] cur_status_c = '0;
  logic [7:0] midibyte_nr_c = '0;
  logic [7:0] midi_in_data_c = '0;
  logic ovf_clr = 1'b0;
  logic byteready, sel, locked, timeout, ovf_u, ovf_c;
  logic [7:0] cur_status, midibyte_nr, midi_in_data;

  midi_src_arbiter #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .reg_clk(reg_clk),
    .reset_reg_N(reset_reg_N),
    .byteready_u(byteready_u),
    .cur_status_u(cur_status_u),
    .midibyte_nr_u(midibyte_nr_u),
    .midi_in_data_u(midi_in_data_u),
    .byteready_c(byteready_c),
    .cur_status_c(cur_status_c),
    .midibyte_nr_c(midibyte_nr_c),
    .midi_in_data_c(midi_in_data_c),
    .ovf_clr(ovf_clr),
    .byteready(byteready),
    .cur_status(cur_status),
    .midibyte_nr(midibyte_nr),
    .midi_in_data(midi_in_data),
    .sel(sel),
    .locked(locked),
    .timeout(timeout),
    .ovf_u(ovf_u),
    .ovf_c(ovf_c)
  );

  always #5 reg_clk = ~reg_clk;

  int n_pass = 0;
  int n_tot = 0;

  // reference model state
  logic [23:0] qu[$];
  logic [23:0] qc[$];
  int mode = 0;
  int stall = 0;
  bit m_last_u = 0;
  bit m_br = 0, m_sel = 0, m_to = 0, m_ou = 0, m_oc = 0;
  logic [23:0] m_e = '0;

  logic [24:0] outq[$];
  logic [24:0] expq[$];

  typedef struct {
    logic [23:0] e;
    logic lock;
  } vec_t;
  vec_t tv[19];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic int ref_len(logic [7:0] s);
    if (s < 8'h80) return 1;
    if (s < 8'hC0) return 3;
    if (s < 8'hE0) return 2;
    if (s < 8'hF0) return 3;
    if (s == 8'hF1 || s == 8'hF3) return 2;
    if (s == 8'hF2) return 3;
    return 1;
  endfunction

  function automatic bit ref_done(logic [23:0] e);
    if (e[23:16] == 8'hF0) return e[7:0] == 8'hF7;
    return int'(e[15:8]) + 1 >= ref_len(e[23:16]);
  endfunction

  function automatic logic [29:0] dut_vec();
    return {byteready, cur_status, midibyte_nr, midi_in_data,
            sel, locked, timeout, ovf_u, ovf_c};
  endfunction

  function automatic logic [29:0] exp_vec();
    return {m_br, m_e, m_sel, mode != 0, m_to, m_ou, m_oc};
  endfunction

  task automatic model_tick();
    bit pu, pc, su, sc;
    logic [23:0] h;
    pu = 0; pc = 0; su = 0; sc = 0;
    if (!reset_reg_N) begin
      qu.delete(); qc.delete();
      mode = 0; stall = 0; m_last_u = 0;
      m_br = 0; m_e = '0; m_sel = 0;
      m_to = 0; m_ou = 0; m_oc = 0;
      return;
    end
    m_to = 0;
    if (mode == 0) begin
      if (qu.size() > 0 && (qc.size() == 0 || !m_last_u)) pu = 1;
      else if (qc.size() > 0) pc = 1;
    end else if (mode == 1) begin
      if (qu.size() > 0) pu = 1;
      else if (stall == TO - 1) begin
        m_to = 1; mode = 0; m_last_u = 1; stall = 0;
      end else stall++;
    end else begin
      if (qc.size() > 0) pc = 1;
      else if (stall == TO - 1) begin
        m_to = 1; mode = 0; m_last_u = 0; stall = 0;
      end else stall++;
    end
    m_br = pu | pc;
    if (m_br) begin
      if (pu) h = qu.pop_front();
      else h = qc.pop_front();
      m_e = h;
      m_sel = pu;
      if (mode == 0) m_last_u = pu;
      mode = ref_done(h) ? 0 : (pu ? 1 : 2);
      stall = 0;
    end
    if (byteready_u) begin
      if (qu.size() < DEPTH)
        qu.push_back({cur_status_u, midibyte_nr_u, midi_in_data_u});
      else su = 1;
    end
    if (byteready_c) begin
      if (qc.size() < DEPTH)
        qc.push_back({cur_status_c, midibyte_nr_c, midi_in_data_c});
      else sc = 1;
    end
    m_ou = su | (m_ou & !ovf_clr);
    m_oc = sc | (m_oc & !ovf_clr);
  endtask

  task automatic step();
    @(posedge reg_clk);
    model_tick();
    #1;
    chk("cycle", 64'(dut_vec()), 64'(exp_vec()));
    if (byteready)
      outq.push_back({sel, cur_status, midibyte_nr, midi_in_data});
  endtask

  task automatic put(bit bu, logic [23:0] eu, bit bc, logic [23:0] ec);
    byteready_u = bu;
    {cur_status_u, midibyte_nr_u, midi_in_data_u} = eu;
    byteready_c = bc;
    {cur_status_c, midibyte_nr_c, midi_in_data_c} = ec;
    step();
    byteready_u = 1'b0;
    byteready_c = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_reg_N = 1'b0;
    step();
    reset_reg_N = 1'b1;
    outq.delete();
  endtask

  task automatic cmp_out(string nm);
    int n;
    chk({nm, "_count"}, 64'(outq.size()), 64'(expq.size()));
    n = (outq.size() < expq.size()) ? outq.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", nm, i), 64'(outq[i]), 64'(expq[i]));
    outq.delete();
    expq.delete();
  endtask

  function automatic logic [23:0] rnd_e();
    logic [7:0] s, d;
    case ($urandom % 8)
      0: s = 8'h90;
      1: s = 8'hC0;
      2: s = 8'hF0;
      3: s = 8'hF8;
      4: s = 8'hF2;
      5: s = 8'h40;
      6: s = 8'hB0;
      default: s = 8'hE0;
    endcase
    d = (($urandom % 4) == 0) ? 8'hF7 : 8'($urandom);
    return {s, 8'($urandom % 4), d};
  endfunction

  initial begin
    int tk;
    bit hit;

    tv[0]  = '{24'h900040, 1'b1};
    tv[1]  = '{24'h900240, 1'b0};
    tv[2]  = '{24'hC00005, 1'b1};
    tv[3]  = '{24'hC00105, 1'b0};
    tv[4]  = '{24'hD00110, 1'b0};
    tv[5]  = '{24'hE00120, 1'b1};
    tv[6]  = '{24'hF10030, 1'b1};
    tv[7]  = '{24'hF10131, 1'b0};
    tv[8]  = '{24'hF20101, 1'b1};
    tv[9]  = '{24'hF20202, 1'b0};
    tv[10] = '{24'hF30007, 1'b1};
    tv[11] = '{24'hF600F6, 1'b0};
    tv[12] = '{24'hF800F8, 1'b0};
    tv[13] = '{24'hFF00FF, 1'b0};
    tv[14] = '{24'h400011, 1'b0};
    tv[15] = '{24'hF000F0, 1'b1};
    tv[16] = '{24'hF003F7, 1'b0};
    tv[17] = '{24'hB00233, 1'b0};
    tv[18] = '{24'hA00044, 1'b1};

    reset_reg_N = 1'b0;
    step();
    step();
    chk("reset_state", 64'(dut_vec()), 64'd0);
    reset_reg_N = 1'b1;

    // message length / completion table
    for (int i = 0; i < 19; i++) begin
      do_reset();
      put(1, tv[i].e, 0, 24'h0);
      step();
      chk($sformatf("len_%0d", i),
          {byteready, locked, cur_status, midibyte_nr, midi_in_data},
          {1'b1, tv[i].lock, tv[i].e});
    end

    // single source, latency 2
    do_reset();
    put(1, 24'h900090, 0, 24'h0);
    put(1, 24'h90013C, 0, 24'h0);
    chk("lat", {byteready, sel, midi_in_data}, {1'b1, 1'b1, 8'h90});
    put(1, 24'h900264, 0, 24'h0);
    chk("ss_lock", 64'(locked), 64'd1);
    idle(4);
    expq = '{25'h1900090, 25'h190013C, 25'h1900264};
    cmp_out("single");

    // contention: u wins first tie
    do_reset();
    put(1, 24'h900090, 1, 24'hC000C0);
    put(1, 24'h90013C, 1, 24'hC00105);
    put(1, 24'h900264, 0, 24'h0);
    idle(8);
    expq = '{25'h1900090, 25'h190013C, 25'h1900264,
             25'h0C000C0, 25'h0C00105};
    cmp_out("cont1");

    // collision right after a u grant goes to c
    put(1, 24'hF800F8, 0, 24'h0);
    idle(3);
    put(1, 24'h900090, 1, 24'hC000C0);
    put(1, 24'h90013C, 1, 24'hC00105);
    put(1, 24'h900264, 0, 24'h0);
    idle(8);
    expq = '{25'h1F800F8, 25'h0C000C0, 25'h0C00105,
             25'h1900090, 25'h190013C, 25'h1900264};
    cmp_out("cont2");

    // sysex holds the lock until F7
    do_reset();
    put(0, 24'h0, 1, 24'hF000F0);
    put(1, 24'hF800F8, 1, 24'hF0017E);
    put(1, 24'hF800F8, 1, 24'hF0027F);
    put(1, 24'hF800F8, 1, 24'hF003F7);
    idle(8);
    expq = '{25'h0F000F0, 25'h0F0017E, 25'h0F0027F, 25'h0F003F7,
             25'h1F800F8, 25'h1F800F8, 25'h1F800F8};
    cmp_out("sysex");

    // overflow of c while u is locked
    do_reset();
    put(1, 24'h900090, 0, 24'h0);
    step();
    put(0, 24'h0, 1, 24'hC000C0);
    put(0, 24'h0, 1, 24'hC00105);
    put(0, 24'h0, 1, 24'hC000C1);
    put(0, 24'h0, 1, 24'hC00106);
    put(0, 24'h0, 1, 24'hC000C2);
    chk("ovf_set", {ovf_u, ovf_c}, 2'b01);
    put(1, 24'h90013C, 0, 24'h0);
    put(1, 24'h900264, 0, 24'h0);
    idle(8);
    expq = '{25'h1900090, 25'h190013C, 25'h1900264,
             25'h0C000C0, 25'h0C00105, 25'h0C000C1, 25'h0C00106};
    cmp_out("ovf");
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", {ovf_u, ovf_c}, 2'b00);

    // stall timeout releases u, pending c goes next
    do_reset();
    put(1, 24'h900090, 0, 24'h0);
    step();
    chk("to_first", {byteready, locked}, 2'b11);
    hit = 0;
    tk = 0;
    for (int k = 1; k <= 40 && !hit; k++) begin
      if (k == 5) begin
        byteready_c = 1'b1;
        {cur_status_c, midibyte_nr_c, midi_in_data_c} = 24'hF800F8;
      end
      step();
      byteready_c = 1'b0;
      if (timeout) begin
        hit = 1;
        tk = k;
        chk("to_lock", 64'(locked), 64'd0);
      end
    end
    chk("to_delay", 64'(tk), 64'd16);
    step();
    chk("to_next", {byteready, sel, midi_in_data},
        {1'b1, 1'b0, 8'hF8});

    // reset mid-message drops the tail
    do_reset();
    put(1, 24'h900090, 0, 24'h0);
    put(1, 24'h90013C, 0, 24'h0);
    put(1, 24'h900264, 0, 24'h0);
    chk("rst_pre", {byteready, midi_in_data}, {1'b1, 8'h3C});
    reset_reg_N = 1'b0;
    step();
    chk("rst_out", 64'(dut_vec()), 64'd0);
    reset_reg_N = 1'b1;
    outq.delete();
    idle(8);
    chk("rst_tail", 64'(outq.size()), 64'd0);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      byteready_u = ($urandom % 3) == 0;
      {cur_status_u, midibyte_nr_u, midi_in_data_u} = rnd_e();
      byteready_c = ($urandom % 3) == 0;
      {cur_status_c, midibyte_nr_c, midi_in_data_c} = rnd_e();
      ovf_clr = ($urandom % 12) == 0;
      reset_reg_N = ($urandom % 300) != 0;
      step();
    end
    byteready_u = 1'b0;
    byteready_c = 1'b0;
    ovf_clr = 1'b0;
    reset_reg_N = 1'b1;
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
